chargen_ctrl: RTL

Sequencer for the character-generator path. Fills the negative-logic 8-bit FIFO with the RFC 864 rotating printable-ASCII pattern and drains it to a byte sink over a valid/ready handshake. It drives the FIFO's write and read strobes, obeys its full and empty flags, and is the only writer and the only reader of that FIFO.

---
 rtl/chargen_ctrl.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/chargen_ctrl.sv
`default_nettype none
//==============================================================================
// Module   : chargen_ctrl
// Brief    : RFC 864 character-generator sequencer. It fills an external
//            negative-logic FIFO and drains it to a valid/ready byte sink.
// Revision : 1.0 - initial release
//==============================================================================
module chargen_ctrl #(
    parameter int         LINE_LEN   = 72,
    parameter logic [7:0] FIRST_CHAR = 8'h20,
    parameter logic [7:0] LAST_CHAR  = 8'h7E
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        n_en,
    output logic [7:0]  fifo_in,
    output logic        n_wr,
    input  logic        n_full,
    input  logic [7:0]  fifo_out,
    output logic        n_rd,
    input  logic        n_empty,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [15:0] lines_done
);

    localparam logic [6:0] C_CR_COL = 7'(LINE_LEN);
    localparam logic [6:0] C_LF_COL = 7'(LINE_LEN + 1);
    localparam logic [7:0] C_CR     = 8'h0D;
    localparam logic [7:0] C_LF     = 8'h0A;

    typedef enum logic [1:0] {W_IDLE, W_STROBE, W_GAP} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_LOAD, R_PRESENT} rstate_t;

    wstate_t    r_wstate, w_wstate_nx;
    rstate_t    r_rstate, w_rstate_nx;
    logic [6:0] r_col;
    logic [7:0] r_line_start;
    logic [7:0] r_cur_char;

    logic       w_wr_go;
    logic       w_rd_go;
    logic       w_load;
    logic       w_accept;
    logic [7:0] w_symbol;

    // Ring successor: the wrap is an equality test, never an 8-bit overflow.
    function automatic logic [7:0] next_char(input logic [7:0] c);
        return (c == LAST_CHAR) ? FIRST_CHAR : c + 8'd1;
    endfunction

    always_comb begin
        w_wr_go     = 1'b0;
        w_wstate_nx = r_wstate;
        case (r_wstate)
            W_IDLE: begin
                if (!n_en && n_full) begin
                    w_wr_go     = 1'b1;
                    w_wstate_nx = W_STROBE;
                end
            end
            W_STROBE: w_wstate_nx = W_GAP;
            W_GAP:    w_wstate_nx = W_IDLE;
            default:  w_wstate_nx = W_IDLE;
        endcase
    end

    always_comb begin
        w_symbol = r_cur_char;
        if (r_col == C_CR_COL) begin
            w_symbol = C_CR;
        end else if (r_col == C_LF_COL) begin
            w_symbol = C_LF;
        end
    end

    always_comb begin
        w_rd_go     = 1'b0;
        w_load      = 1'b0;
        w_accept    = 1'b0;
        w_rstate_nx = r_rstate;
        case (r_rstate)
            R_IDLE: begin
                if (n_empty) begin
                    w_rd_go     = 1'b1;
                    w_rstate_nx = R_FETCH;
                end
            end
            R_FETCH: w_rstate_nx = R_LOAD;
            R_LOAD: begin
                w_load      = 1'b1;
                w_rstate_nx = R_PRESENT;
            end
            R_PRESENT: begin
                if (tx_ready) begin
                    w_accept    = 1'b1;
                    w_rstate_nx = R_IDLE;
                end
            end
            default: w_rstate_nx = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_wstate <= W_IDLE;
            r_rstate <= R_IDLE;
        end else begin
            r_wstate <= w_wstate_nx;
            r_rstate <= w_rstate_nx;
        end
    end

    // Writer datapath: the symbol pointer moves on entry to W_STROBE.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            n_wr         <= 1'b1;
            fifo_in      <= 8'h00;
            r_col        <= 7'd0;
            r_line_start <= FIRST_CHAR;
            r_cur_char   <= FIRST_CHAR;
            lines_done   <= 16'd0;
        end else begin
            n_wr <= !w_wr_go;
            if (w_wr_go) begin
                fifo_in <= w_symbol;
                if (r_col == C_LF_COL) begin
                    r_col        <= 7'd0;
                    r_line_start <= next_char(r_line_start);
                    r_cur_char   <= next_char(r_line_start);
                    lines_done   <= lines_done + 16'd1;
                end else begin
                    r_col <= r_col + 7'd1;
                    if (r_col < C_CR_COL) begin
                        r_cur_char <= next_char(r_cur_char);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            n_rd     <= 1'b1;
            tx_data  <= 8'h00;
            tx_valid <= 1'b0;
        end else begin
            n_rd <= !w_rd_go;
            if (w_load) begin
                tx_data  <= fifo_out;
                tx_valid <= 1'b1;
            end else if (w_accept) begin
                tx_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
